shift_rotate_sequencer: RTL and testbench

Multi-cycle controller for the 4-bit single-step logic shift/rotate datapath (`Logic_Shift_Rotate_Top_Module`). It accepts a shift or rotate command with a repeat count and captures the selected operand. It then iterates the one-position datapath once per clock until the count is exhausted, and returns the final 4-bit result with a busy/done handshake. It sits between the ALSU operation decoder and the shift/rotate unit, and is the only driver of that unit's `A`, `B` and `Sel` inputs.

---
 rtl/shift_rotate_sequencer.sv | 123 ++++++++++++
 tb/tb_shift_rotate_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate sequencer driving a single-step 4-bit shift/rotate datapath.
// Optional macro SHIFT_SEQ_FASTPATH_EN reduces the iteration count without changing results.

module Logic_Shift_Rotate_Top_Module (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] Sel,
  output logic [3:0] Out
);
  always_comb begin
    Out = 4'b0000;
    case (Sel)
      3'b000: Out = {1'b0, A[3:1]};
      3'b001: Out = {A[2:0], 1'b0};
      3'b010: Out = {1'b0, B[3:1]};
      3'b011: Out = {B[2:0], 1'b0};
      3'b100: Out = {A[0], A[3:1]};
      3'b101: Out = {A[2:0], A[3]};
      3'b110: Out = {B[0], B[3:1]};
      3'b111: Out = {B[2:0], B[3]};
    endcase
  end
endmodule

module shift_rotate_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [2:0]       Sel,
  input  logic [CNT_W-1:0] Amount,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       work_reg, work_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [3:0]       result_reg, result_next;
  logic [CNT_W-1:0] eff_amount;
  logic [3:0]       dp_a, dp_b, step;
  logic             op_uses_a;

  // Codes 000/001/100/101 operate on A; bit 1 alone distinguishes the operand.
  assign op_uses_a = ~op_reg[1];
  assign dp_a      = op_uses_a ? work_reg : 4'b0000;
  assign dp_b      = op_uses_a ? 4'b0000  : work_reg;

  Logic_Shift_Rotate_Top_Module u_step (
    .A   (dp_a),
    .B   (dp_b),
    .Sel (op_reg),
    .Out (step)
  );

`ifdef SHIFT_SEQ_FASTPATH_EN
  // Four rotations are the identity and four shifts already clear the word.
  always_comb begin
    eff_amount = Amount;
    if (Sel[2])
      eff_amount = Amount & CNT_W'(3);
    else if (32'(Amount) > 32'd4)
      eff_amount = CNT_W'(4);
  end
`else
  assign eff_amount = Amount;
`endif

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          work_next  = Sel[1] ? B : A;
          op_next    = Sel;
          cnt_next   = eff_amount;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == '0) begin
          result_next = work_reg;
          state_next  = DONE;
        end else begin
          work_next = step;
          cnt_next  = cnt_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      work_reg   <= 4'b0000;
      cnt_reg    <= '0;
      op_reg     <= 3'b000;
      result_reg <= 4'b0000;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  assign Busy   = (state_reg != IDLE);
  assign Done   = (state_reg == DONE);
  assign Result = result_reg;
endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Directed bench for shift_rotate_sequencer: expected results queued at issue, checked at Done.
// Honours SHIFT_SEQ_FASTPATH_EN for expected latency.

module tb_shift_rotate_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             Start = 1'b0;
  logic [3:0]       A = '0;
  logic [3:0]       B = '0;
  logic [2:0]       Sel = '0;
  logic [CNT_W-1:0] Amount = '0;
  logic             Busy, Done;
  logic [3:0]       Result;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int done_seen = 0;
  int acc_cyc   = 0;
  logic [3:0] exp_q[$];

  shift_rotate_sequencer #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Sel    (Sel),
    .Amount (Amount),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] sel, input int amt);
    logic [3:0] x;
    x = (sel == 3'd0 || sel == 3'd1 || sel == 3'd4 || sel == 3'd5) ? a : b;
    for (int i = 0; i < amt; i++) begin
      if (sel[2] == 1'b0) x = sel[0] ? (x << 1) : (x >> 1);
      else                x = sel[0] ? ((x << 1) | (x >> 3)) : ((x >> 1) | (x << 3));
    end
    return x;
  endfunction

  function automatic int eff(input logic [2:0] sel, input int amt);
`ifdef SHIFT_SEQ_FASTPATH_EN
    if (sel[2]) return amt % 4;
    return (amt > 4) ? 4 : amt;
`else
    return amt;
`endif
  endfunction

  // Drive a command for one accepting edge; leaves the bench #1 after edge 0.
  task automatic start_cmd(input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel, input int amt);
    @(negedge clk);
    A = a; B = b; Sel = sel; Amount = CNT_W'(amt); Start = 1'b1;
    exp_q.push_back(model(a, b, sel, amt));
    @(posedge clk); #1;
    acc_cyc = cyc;
    Start = 1'b0;
    chk("busy_rise", 32'(Busy), 32'd1);
    $display("issue sel=%b a=%b b=%b amt=%0d", sel, a, b, amt);
  endtask

  task automatic wait_done(input string tag, input logic [2:0] sel, input int amt);
    logic [3:0] exp_r;
    int k;
    k = 0;
    while (Done !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(eff(sel, amt) + 1));
    chk({tag, "_busy_at_done"}, 32'(Busy), 32'd1);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    chk({tag, "_result"}, 32'(Result), 32'(exp_r));
    $display("done %s result=%b expected=%b edge=%0d", tag, Result, exp_r, cyc - acc_cyc);
    @(posedge clk); #1;
    chk({tag, "_busy_fall"}, 32'(Busy), 32'd0);
    chk({tag, "_done_fall"}, 32'(Done), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input int amt);
    start_cmd(a, b, sel, amt);
    wait_done(tag, sel, amt);
  endtask

  initial begin
    int d0;
    logic [3:0] ra, rb;
    logic [2:0] rs;
    int ramt;

    #1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_result", 32'(Result), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_cmd("lsl_a", 4'b0011, 4'b0000, 3'b001, 2);
    run_cmd("ror_b", 4'b1111, 4'b0001, 3'b110, 3);
    run_cmd("amt0",  4'b1010, 4'b0000, 3'b100, 0);

    // Second Start during RUN must be dropped; operand changes must not leak in.
    d0 = done_seen;
    start_cmd(4'b1100, 4'b0000, 3'b000, 2);
    @(negedge clk);
    A = 4'b1111; B = 4'b1010; Sel = 3'b111; Amount = 4'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done("ignored_start", 3'b000, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("ignored_start_done_once", 32'(done_seen - d0), 32'd1);

    // Asynchronous reset in the middle of RUN.
    start_cmd(4'b1000, 4'b0000, 3'b000, 5);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'(Busy), 32'd0);
    chk("midrun_rst_done", 32'(Done), 32'd0);
    chk("midrun_rst_result", 32'(Result), 32'd0);
    void'(exp_q.pop_back());
    d0 = done_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrun_rst_no_done", 32'(done_seen - d0), 32'd0);
    $display("reset mid-run discarded command");
    run_cmd("after_rst", 4'b0110, 4'b0000, 3'b001, 1);

    run_cmd("rol9",  4'b1000, 4'b0000, 3'b101, 9);
    run_cmd("lsl15", 4'b1111, 4'b0000, 3'b001, 15);

    // Start held high: re-accepted in the first IDLE cycle after DONE.
    @(negedge clk);
    A = 4'b0101; B = 4'b0000; Sel = 3'b001; Amount = 4'd1; Start = 1'b1;
    exp_q.push_back(model(4'b0101, 4'b0000, 3'b001, 1));
    @(posedge clk); #1;
    acc_cyc = cyc;
    d0 = cyc;
    wait_done("b2b_first", 3'b001, 1);
    A = 4'b0011; Sel = 3'b101; Amount = 4'd2;
    exp_q.push_back(model(4'b0011, 4'b0000, 3'b101, 2));
    @(posedge clk); #1;
    chk("b2b_reaccept_busy", 32'(Busy), 32'd1);
    chk("b2b_interval", 32'(cyc - d0), 32'(eff(3'b001, 1) + 3));
    acc_cyc = cyc;
    Start = 1'b0;
    wait_done("b2b_second", 3'b101, 2);

    for (int i = 0; i < 6; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      ramt = $urandom_range(0, 7);
      run_cmd($sformatf("rand%0d", i), ra, rb, rs, ramt);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
